screen_sequencer: RTL

//  Top-level scene controller for the VGA path. Selects the start, play or

---
 rtl/screen_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/screen_sequencer.sv
// Scene controller for the VGA path: start / play / game-over selection,
// frame-aligned screen changes, game-over timing and registered RGB out.
module screen_sequencer #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int BLINK_FRAMES    = 30,
  parameter int GAMEOVER_FRAMES = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        start_btn,
  input  logic        game_over_evt,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [23:0] start_rgb,
  input  logic [23:0] play_rgb,
  input  logic [23:0] over_rgb,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic [1:0]  screen_sel,
  output logic        screen_changed
);

  localparam int FC_W = $clog2(GAMEOVER_FRAMES + 1);
  localparam int BC_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(GAMEOVER_FRAMES - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);
  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  state_t          state, state_d;
  logic            start_pend, start_pend_d;
  logic            over_pend, over_pend_d;
  logic [FC_W-1:0] frame_cnt, frame_cnt_d;
  logic [BC_W-1:0] blink_cnt, blink_cnt_d;
  logic            blink_phase, blink_phase_d;
  logic [23:0]     rgb_q, rgb_d;
  logic            changed_q;
  logic            start_req, over_req;
  logic            blank;
  logic [23:0]     src_rgb;

  assign start_req = start_pend | start_btn;
  assign over_req  = over_pend | game_over_evt;

  always_comb begin
    state_d       = state;
    start_pend_d  = start_pend;
    over_pend_d   = over_pend;
    frame_cnt_d   = frame_cnt;
    blink_cnt_d   = blink_cnt;
    blink_phase_d = blink_phase;
    if (frame_start) begin
      unique case (state)
        ST_START: begin
          if (start_req) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (over_req) begin
            state_d       = ST_OVER;
            frame_cnt_d   = '0;
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
          end
        end
        ST_OVER: begin
          if (start_req) begin
            state_d = ST_PLAY;
          end else if (frame_cnt == FC_LAST) begin
            state_d = ST_START;
          end else begin
            frame_cnt_d = frame_cnt + 1'b1;
            if (blink_cnt == BC_LAST) begin
              blink_cnt_d   = '0;
              blink_phase_d = ~blink_phase;
            end else begin
              blink_cnt_d = blink_cnt + 1'b1;
            end
          end
        end
        default: state_d = ST_START;
      endcase
    end
    // requests only latch in states that can act on them
    if (state_d != state) begin
      start_pend_d = 1'b0;
      over_pend_d  = 1'b0;
    end else begin
      if (start_btn && state != ST_PLAY)
        start_pend_d = 1'b1;
      if (game_over_evt && state == ST_PLAY)
        over_pend_d = 1'b1;
    end
  end

  always_comb begin
    src_rgb = start_rgb;
    unique case (state)
      ST_START: src_rgb = start_rgb;
      ST_PLAY:  src_rgb = play_rgb;
      ST_OVER:  src_rgb = over_rgb;
      default:  src_rgb = start_rgb;
    endcase
    blank = (x >= H_LIM) || (y >= V_LIM)
         || (state == ST_OVER && blink_phase);
    rgb_d = blank ? 24'h0 : src_rgb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_START;
      start_pend  <= 1'b0;
      over_pend   <= 1'b0;
      frame_cnt   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      rgb_q       <= 24'h0;
      changed_q   <= 1'b0;
    end else begin
      state       <= state_d;
      start_pend  <= start_pend_d;
      over_pend   <= over_pend_d;
      frame_cnt   <= frame_cnt_d;
      blink_cnt   <= blink_cnt_d;
      blink_phase <= blink_phase_d;
      rgb_q       <= rgb_d;
      changed_q   <= (state_d != state);
    end
  end

  assign r              = rgb_q[23:16];
  assign g              = rgb_q[15:8];
  assign b              = rgb_q[7:0];
  assign screen_sel     = state;
  assign screen_changed = changed_q;

endmodule
